// File: rtl/tx_frame_buffer.sv
// Ping-pong sample buffer feeding a UDP/IP send stage: fills one 256x32 bank while the other is sent.
// Optional feature: define TX_BUF_SEQ_HEADER_EN to put a 32-bit frame sequence number in word 0 of each bank.
module tx_frame_buffer #(
    parameter int FRAME_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    input  logic        flush,
    input  logic        tx_busy,
    input  logic [11:0] ram_rd_addr,
    output logic [31:0] ram_rd_data,
    output logic        send_trigger,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic [15:0] overflow_cnt,
    output logic [1:0]  buf_state
);

`ifdef TX_BUF_SEQ_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam logic [8:0] LP_FRAME = 9'(FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TRIG      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_SENDING   = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_mem [2][256];
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic [8:0]  r_wr_cnt;
    logic [1:0]  r_full;
    logic [8:0]  r_len [2];
`ifdef TX_BUF_SEQ_HEADER_EN
    logic [31:0] r_seq;
`endif

    logic        w_stall;
    logic        w_accept;
    logic [8:0]  w_cnt_next;
    logic        w_close;
    logic [7:0]  w_wr_addr;
    logic [8:0]  w_n;
    logic        w_free;
    logic [1:0]  w_full_eff;
    logic        w_swap_ok;
    logic        w_pick;
    logic [8:0]  w_pick_len;
    logic        w_unused;

    // The write bank is itself full only after a close found the other bank busy.
    assign w_stall    = r_full[r_wr_bank];
    assign w_accept   = sample_valid & ~w_stall;
    assign w_cnt_next = r_wr_cnt + {8'd0, w_accept};
    assign w_close    = ~w_stall & ((w_cnt_next == LP_FRAME) | (flush & (w_cnt_next != 9'd0)));
    assign w_wr_addr  = r_wr_cnt[7:0] + 8'(H);
    assign w_n        = w_cnt_next + 9'(H);
    assign w_unused   = &{1'b0, ram_rd_addr[11:8]};

    // NOTE: a bank freed this cycle already counts as free, so a same-cycle close can swap into it.
    always_comb begin
        w_full_eff = r_full;
        if (w_free) begin
            w_full_eff[r_rd_bank] = 1'b0;
        end
    end

    assign w_free     = (r_state == S_SENDING) & ~tx_busy;
    assign w_swap_ok  = ~w_full_eff[~r_wr_bank];
    // With both banks full, the write bank is the newer one, so send the other first.
    assign w_pick     = (&r_full) ? ~r_wr_bank : r_full[1];
    assign w_pick_len = r_len[w_pick];

    // NOTE: the sample RAM has no reset; only its control state is cleared.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_bank][w_wr_addr] <= sample_data;
        end
`ifdef TX_BUF_SEQ_HEADER_EN
        if (w_close) begin
            r_mem[r_wr_bank][0] <= r_seq;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_rd_data <= 32'd0;
        end else begin
            ram_rd_data <= r_mem[r_rd_bank][ram_rd_addr[7:0]];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_bank    <= 1'b0;
            r_wr_cnt     <= 9'd0;
            r_full       <= 2'b00;
            r_len[0]     <= 9'd0;
            r_len[1]     <= 9'd0;
            overflow_cnt <= 16'd0;
`ifdef TX_BUF_SEQ_HEADER_EN
            r_seq        <= 32'd0;
`endif
        end else begin
            if (sample_valid && w_stall && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            if (w_close) begin
                r_full[r_wr_bank] <= 1'b1;
                r_len[r_wr_bank]  <= w_n;
                r_wr_cnt          <= 9'd0;
                if (w_swap_ok) begin
                    r_wr_bank <= ~r_wr_bank;
                end
`ifdef TX_BUF_SEQ_HEADER_EN
                r_seq <= r_seq + 32'd1;
`endif
            end else begin
                r_wr_cnt <= w_cnt_next;
                if (w_stall && w_swap_ok) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_free) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_rd_bank       <= 1'b0;
            send_trigger    <= 1'b0;
            tx_data_length  <= 16'd0;
            tx_total_length <= 16'd0;
        end else begin
            send_trigger <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((|r_full) && !tx_busy) begin
                        r_state         <= S_TRIG;
                        r_rd_bank       <= w_pick;
                        send_trigger    <= 1'b1;
                        tx_data_length  <= 16'd8  + {5'd0, w_pick_len, 2'b00};
                        tx_total_length <= 16'd28 + {5'd0, w_pick_len, 2'b00};
                    end
                end
                S_TRIG:      r_state <= S_WAIT_BUSY;
                S_WAIT_BUSY: if (tx_busy)  r_state <= S_SENDING;
                S_SENDING:   if (!tx_busy) r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    assign buf_state = r_state;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed bench for tx_frame_buffer with FRAME_WORDS=4; a cycle table for one frame plus hand sequences.
module tb_tx_frame_buffer;

`ifdef TX_BUF_SEQ_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam logic [15:0] DLEN4 = 16'(8 + 4 * (4 + H));
    localparam logic [15:0] TLEN4 = 16'(28 + 4 * (4 + H));

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_data = 32'd0;
    logic        flush = 1'b0;
    logic        tx_busy = 1'b0;
    logic [11:0] ram_rd_addr = 12'd0;
    logic [31:0] ram_rd_data;
    logic        send_trigger;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic [15:0] overflow_cnt;
    logic [1:0]  buf_state;

    int n_checks = 0;
    int n_fail   = 0;
    int trig_cnt = 0;
    int t0;

    tx_frame_buffer #(.FRAME_WORDS(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .flush           (flush),
        .tx_busy         (tx_busy),
        .ram_rd_addr     (ram_rd_addr),
        .ram_rd_data     (ram_rd_data),
        .send_trigger    (send_trigger),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .overflow_cnt    (overflow_cnt),
        .buf_state       (buf_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (send_trigger === 1'b1) trig_cnt <= trig_cnt + 1;
    end

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        fl;
        logic        busy;
        logic [11:0] addr;
        logic        exp_trig;
        logic [1:0]  exp_state;
        logic [15:0] exp_dlen;
        logic [15:0] exp_tlen;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        flush = 1'b0;
        tx_busy = 1'b0;
        ram_rd_addr = 12'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int t;
        t = 0;
        while (buf_state !== s && t < 50) begin
            step();
            t++;
        end
        check(name, 32'(buf_state), 32'(s));
    endtask

    // Acts as the send stage: waits for the request, checks lengths, reads the frame back.
    task automatic send_frame(input logic [31:0] base, input int n, input logic [31:0] seq);
        $display("send frame base %h words %0d seq %0d", base, n, seq);
        wait_state(2'd2, "reach_wait_busy");
        check("tx_data_length", 32'(tx_data_length), 32'(8 + 4 * (n + H)));
        check("tx_total_length", 32'(tx_total_length), 32'(28 + 4 * (n + H)));
        tx_busy = 1'b1;
        step();
        check("state_sending", 32'(buf_state), 32'd3);
`ifdef TX_BUF_SEQ_HEADER_EN
        ram_rd_addr = 12'd0;
        step();
        check("header_seq", ram_rd_data, seq);
`endif
        for (int i = 0; i < n; i++) begin
            ram_rd_addr = 12'(H + i);
            step();
            check("frame_word", ram_rd_data, base + 32'(i));
        end
        tx_busy = 1'b0;
        step();
        check("state_idle_after_send", 32'(buf_state), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 12'd0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 12'd0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 12'd0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 32'd0};
        vecs[3]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 12'd0, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 12'd0, 1'b1, 2'd1, DLEN4, TLEN4, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 12'd0, 1'b0, 2'd2, DLEN4, TLEN4, 1'b0, 32'd0};
        vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 12'd0, 1'b0, 2'd3, DLEN4, TLEN4, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 12'(H + 0), 1'b0, 2'd3, DLEN4, TLEN4, 1'b1, 32'hA0};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 12'(H + 1), 1'b0, 2'd3, DLEN4, TLEN4, 1'b1, 32'hA1};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 12'(H + 2), 1'b0, 2'd3, DLEN4, TLEN4, 1'b1, 32'hA2};
        vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 12'(H + 3), 1'b0, 2'd3, DLEN4, TLEN4, 1'b1, 32'hA3};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 1'b0, 12'd0, 1'b0, 2'd0, DLEN4, TLEN4, 1'b0, 32'd0};
        vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 12'd0, 1'b0, 2'd0, DLEN4, TLEN4, 1'b0, 32'd0};

        // Reset state, observed while reset is held.
        reset = 1'b1;
        step();
        step();
        check("rst_state", 32'(buf_state), 32'd0);
        check("rst_trigger", 32'(send_trigger), 32'd0);
        check("rst_dlen", 32'(tx_data_length), 32'd0);
        check("rst_tlen", 32'(tx_total_length), 32'd0);
        check("rst_overflow", 32'(overflow_cnt), 32'd0);
        check("rst_rd_data", ram_rd_data, 32'd0);
        reset = 1'b0;

        // One full frame, cycle by cycle.
        t0 = trig_cnt;
        for (int i = 0; i < 13; i++) begin
            sample_valid = vecs[i].valid;
            sample_data  = vecs[i].data;
            flush        = vecs[i].fl;
            tx_busy      = vecs[i].busy;
            ram_rd_addr  = vecs[i].addr;
            step();
            check($sformatf("v%0d_trigger", i), 32'(send_trigger), 32'(vecs[i].exp_trig));
            check($sformatf("v%0d_state", i), 32'(buf_state), 32'(vecs[i].exp_state));
            check($sformatf("v%0d_dlen", i), 32'(tx_data_length), 32'(vecs[i].exp_dlen));
            check($sformatf("v%0d_tlen", i), 32'(tx_total_length), 32'(vecs[i].exp_tlen));
            if (vecs[i].chk_rd) check($sformatf("v%0d_rd_data", i), ram_rd_data, vecs[i].exp_rd);
        end
        sample_valid = 1'b0;
        tx_busy = 1'b0;
        check("table_one_trigger", 32'(trig_cnt - t0), 32'd1);

        // Partial frame closed by flush; empty flush ignored; flush on the last sample closes once.
        do_reset();
        push(32'hB0);
        push(32'hB1);
        push(32'hB2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        send_frame(32'hB0, 3, 32'd0);
        t0 = trig_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (10) step();
        check("empty_flush_no_trigger", 32'(trig_cnt - t0), 32'd0);
        push(32'hB10);
        push(32'hB11);
        push(32'hB12);
        flush = 1'b1;
        push(32'hB13);
        flush = 1'b0;
        send_frame(32'hB10, 4, 32'd1);
        repeat (10) step();
        check("flush_last_single_close", 32'(trig_cnt - t0), 32'd1);

        // Send stage busy: two banks fill, third frame dropped, then oldest first.
        do_reset();
        t0 = trig_cnt;
        tx_busy = 1'b1;
        for (int i = 0; i < 12; i++) push(32'hC00 + 32'(i));
        step();
        check("busy_overflow_cnt", 32'(overflow_cnt), 32'd4);
        check("busy_no_trigger", 32'(trig_cnt - t0), 32'd0);
        tx_busy = 1'b0;
        send_frame(32'hC00, 4, 32'd0);
        send_frame(32'hC04, 4, 32'd1);
        repeat (10) step();
        check("busy_two_triggers", 32'(trig_cnt - t0), 32'd2);
        check("busy_final_idle", 32'(buf_state), 32'd0);

        // Bank freed on the same cycle the other bank closes.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'hE0 + 32'(i));
        wait_state(2'd2, "coinc_wait_busy");
        tx_busy = 1'b1;
        step();
        push(32'hE4);
        push(32'hE5);
        push(32'hE6);
        tx_busy = 1'b0;
        push(32'hE7);
        check("coinc_freed_idle", 32'(buf_state), 32'd0);
        for (int i = 0; i < 4; i++) push(32'hE8 + 32'(i));
        step();
        check("coinc_overflow_zero", 32'(overflow_cnt), 32'd0);
        send_frame(32'hE4, 4, 32'd1);
        send_frame(32'hE8, 4, 32'd2);
        check("coinc_overflow_end", 32'(overflow_cnt), 32'd0);

        // Reset while sending, with a partial frame pending.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'hF0 + 32'(i));
        wait_state(2'd2, "rst_mid_wait_busy");
        tx_busy = 1'b1;
        step();
        check("rst_mid_sending", 32'(buf_state), 32'd3);
        push(32'hF4);
        push(32'hF5);
        reset = 1'b1;
        step();
        check("rst_mid_state", 32'(buf_state), 32'd0);
        check("rst_mid_trigger", 32'(send_trigger), 32'd0);
        check("rst_mid_dlen", 32'(tx_data_length), 32'd0);
        check("rst_mid_tlen", 32'(tx_total_length), 32'd0);
        check("rst_mid_overflow", 32'(overflow_cnt), 32'd0);
        check("rst_mid_rd_data", ram_rd_data, 32'd0);
        reset = 1'b0;
        tx_busy = 1'b0;
        t0 = trig_cnt;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (20) step();
        check("rst_mid_no_trigger", 32'(trig_cnt - t0), 32'd0);
        check("rst_mid_idle", 32'(buf_state), 32'd0);
        for (int i = 0; i < 4; i++) push(32'h90 + 32'(i));
        send_frame(32'h90, 4, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
